mdu_unit: RTL

- Multiply/divide unit that consumes the two register-file read ports (RD1 → A, RD2 → B) in the execute stage.
- Owns the HI/LO architectural registers.
- Implements mult, multu, div, divu, mthi and mtlo with fixed multi-cycle latency.
- Raises busy so the controller can stall dependent MDU instructions; mfhi/mflo read the hi/lo outputs.

---
 rtl/mdu_unit_pkg.sv | 76 +++++++
 rtl/mdu_unit_if.sv | 27 ++
 rtl/mdu_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the combinational arithmetic used at the start edge.
package mdu_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } mdu_res_t;

  // Division works on magnitudes so 0x80000000 / -1 falls out naturally as
  // quotient 0x80000000, remainder 0 after sign restoration.
  function automatic mdu_res_t mdu_compute(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    mdu_res_t    res;
    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] prod;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    res   = '0;
    sgn   = (op == MDU_MULT) || (op == MDU_DIV);
    ea    = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb    = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    prod  = ea * eb;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? -a : a;
    mb    = neg_b ? -b : b;
    dv    = (mb == 32'd0) ? 32'd1 : mb;
    q     = ma / dv;
    r     = ma % dv;
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        res.hi   = r;
        res.lo   = q;
        res.div0 = (b == 32'd0);
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Execute-stage connection between the controller and the MDU.
interface mdu_unit_if;
  import mdu_unit_pkg::*;

  // start/mdu_op/A/B form a single-cycle request; it is taken only while
  // busy is low (and the unit is IDLE at that edge). Requests seen while busy
  // are dropped silently, so the controller must stall on busy.
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_e  state;

  modport master (
    output start, mdu_op, A, B,
    input  busy, hi, lo, state
  );

  modport slave (
    input  start, mdu_op, A, B,
    output busy, hi, lo, state
  );

endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at the
// start edge and committed to HI/LO when the latency counter expires.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       rst,
  mdu_unit_if.slave bus
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      tmp_hi_q;
  logic [31:0]      tmp_lo_q;
  logic             div0_q;

  mdu_res_t res_d;
  logic     is_mul;
  logic     is_div;

  always_comb begin
    res_d  = mdu_compute(bus.mdu_op, bus.A, bus.B);
    is_mul = (bus.mdu_op == MDU_MULT) || (bus.mdu_op == MDU_MULTU);
    is_div = (bus.mdu_op == MDU_DIV) || (bus.mdu_op == MDU_DIVU);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_mul || is_div) begin
              tmp_hi_q <= res_d.hi;
              tmp_lo_q <= res_d.lo;
              div0_q   <= res_d.div0;
              cnt_q    <= is_div ? DIV_LOAD : MULT_LOAD;
              state_q  <= BUSY;
            end else if (bus.mdu_op == MDU_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.mdu_op == MDU_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          if (cnt_q == CNT_ONE) begin
            if (!div0_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q == BUSY);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state_q;

endmodule
